calc_sequencer: RTL
===================

# calc_sequencer

Sequencing controller for the 4-bit arithmetic datapath. It converts raw operation buttons into single, edge-triggered operation requests and latches both operands from the switches. It drives operands and a one-hot op code to the datapath for a fixed settle window, then captures result and overflow into display registers. It also supplies the free-running 16-bit counter that the datapath shows in its pass-through mode.

## Interface
- EXEC_CYCLES, 2, cycles op_po is held before capture; legal range 1..15
- CNT_W, 16, width of free-running counter

- clk_pi  in  1  system clock, rising-edge
- reset_pi  in  1  synchronous, active-high reset
- btn_pi  in  4  op buttons, level-high, already synchronized; [0]=add, [1]=sub, [2]=mul, [3]=clear
- sw_a_pi  in  4  operand A switches
- sw_b_pi  in  4  operand B switches
- calc_result_pi  in  8  datapath result
- calc_ovflw_pi  in  1  datapath overflow
- data1_po  out  4  operand A to datapath (registered)
- data2_po  out  4  operand B to datapath (registered)
- op_po  out  4  one-hot op to datapath: 0001 add, 0010 sub, 0100 mul; 0000 when not executing
- counter_po  out  CNT_W  free-running counter to datapath
- result_po  out  8  captured result (registered)
- ovflw_po  out  1  captured overflow (registered)
- busy_po  out  1  high in any state except IDLE
- done_po  out  1  one-cycle pulse on capture or clear

## Operation
- Reset values:
  - data1_po=0, data2_po=0, op_po=0000, counter_po=0
  - result_po=0x00, ovflw_po=0, busy_po=0, done_po=0
  - btn history=0, state=IDLE
- Edge detect: press = btn_pi & ~btn_q; btn_q is the register of btn_pi and updates every cycle in all states.
- Simultaneous presses: lowest index wins (add > sub > mul > clear); the others are discarded.
- States:
  - IDLE: op_po=0000.
    - On a press of bit 0..2: latch sw_a_pi→data1_po and sw_b_pi→data2_po, set op_po to the matching one-hot code, load the exec counter with EXEC_CYCLES-1, go to EXEC.
    - On a press of bit 3 only: result_po=0, ovflw_po=0, pulse done_po, go to WAIT_REL. Operands are unchanged.
  - EXEC: hold the operands and op_po; decrement the exec counter.
    - When the counter is 0: capture calc_result_pi→result_po and set ovflw_po.
    - ovflw_po takes calc_ovflw_pi for add/sub and is forced to 0 for mul.
    - Pulse done_po, set op_po=0000, go to WAIT_REL.
  - WAIT_REL: go to IDLE on the first cycle btn_pi==0000.
- All presses in EXEC or WAIT_REL are ignored and are not queued.
- counter_po increments every cycle in all states and wraps from 2^CNT_W-1 to 0.
- Arithmetic is performed by the datapath only; this block does no arithmetic besides its counters.

## Timing
- Press sampled at edge E0 (btn_pi=1, btn_q=0, state IDLE).
  - Operands and op_po are valid after E0.
  - result_po, ovflw_po and done_po update at edge E0+EXEC_CYCLES.
  - done_po is high for exactly one cycle.
- Clear: result_po=0 and done_po=1 after E0, with no EXEC phase.
- busy_po rises after E0 and falls after the first edge that samples btn_pi==0000 in WAIT_REL.
- A button held through the whole operation produces exactly one operation.
- A new press needs a release (btn_pi==0000 sampled in WAIT_REL) first, then a fresh rising edge seen in IDLE.
- A button already high when IDLE is re-entered is not a press.
- Switch changes after E0 do not affect data1_po/data2_po until the next accepted press.
- reset_pi asserted in any state: every output takes its reset value at that edge. The in-flight operation is discarded and no done_po is produced.
- Reset has priority over all presses in the same cycle.

## Test plan
- Reset, then A=9, B=8, press btn[0] for 1 cycle, EXEC_CYCLES=2 → op_po=0001 for 2 cycles; at E0+2 result_po=0x01, ovflw_po=1, single done_po.
- A=3, B=5, press btn[1] held 20 cycles → one operation: result_po=0x0E, ovflw_po=1; busy_po stays high until release; no second done_po.
- A=15, B=15, press btn[2] → result_po=0xE1, ovflw_po=0 even if calc_ovflw_pi is driven 1.
- btn_pi=0110 asserted in one cycle → sub executed (op_po=0010); then btn[3] after release → result_po=0x00, done_po 1 cycle, op_po stays 0000.
- Assert reset_pi at the second EXEC cycle of an add → all outputs return to reset values next cycle; no done_po; counter_po=0 then counts 1,2,3.
- Run 65536 cycles from reset → counter_po wraps 0xFFFF→0x0000. Pressing btn[0] during WAIT_REL is ignored: no extra done_po.

Source files
------------

// File: rtl/calc_sequencer_if.sv
// Bundle between the calculator sequencer and its surroundings: button and switch
// inputs, the datapath result path, and the operand/op/display outputs.
interface calc_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       btn_pi;
  logic [3:0]       sw_a_pi;
  logic [3:0]       sw_b_pi;
  logic [7:0]       calc_result_pi;
  logic             calc_ovflw_pi;

  logic [3:0]       data1_po;
  logic [3:0]       data2_po;
  logic [3:0]       op_po;
  logic [CNT_W-1:0] counter_po;
  logic [7:0]       result_po;
  logic             ovflw_po;
  logic             busy_po;
  logic             done_po;

  // The sequencer side.
  modport master (
    input  btn_pi, sw_a_pi, sw_b_pi, calc_result_pi, calc_ovflw_pi,
    output data1_po, data2_po, op_po, counter_po, result_po, ovflw_po, busy_po, done_po
  );

  // Buttons, switches, datapath and display.
  modport slave (
    output btn_pi, sw_a_pi, sw_b_pi, calc_result_pi, calc_ovflw_pi,
    input  data1_po, data2_po, op_po, counter_po, result_po, ovflw_po, busy_po, done_po
  );
endinterface

// File: rtl/calc_sequencer.sv
// Sequencer for the 4-bit calculator: edge-detects op buttons, latches operands,
// holds the op for a settle window, then captures result/overflow for display.
module calc_sequencer #(
  parameter int EXEC_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input logic              clk_pi,
  input logic              reset_pi,
  calc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT_REL
  } state_t;

  localparam logic [3:0]       EXEC_LOAD = 4'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t     state_q;
  logic [3:0] btn_q;
  logic [3:0] exec_cnt_q;
  logic [3:0] press;
  logic [3:0] op_sel;

  assign press = bus.btn_pi & ~btn_q;

  // Lowest button index wins when several rise together; clear is handled separately.
  // NOTE: op_sel gets a default before the if-chain so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    op_sel = 4'b0000;
    if (press[0])      op_sel = 4'b0001;
    else if (press[1]) op_sel = 4'b0010;
    else if (press[2]) op_sel = 4'b0100;
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_q        <= IDLE;
      btn_q          <= 4'b0000;
      exec_cnt_q     <= 4'd0;
      bus.data1_po   <= 4'd0;
      bus.data2_po   <= 4'd0;
      bus.op_po      <= 4'b0000;
      bus.counter_po <= '0;
      bus.result_po  <= 8'h00;
      bus.ovflw_po   <= 1'b0;
      bus.busy_po    <= 1'b0;
      bus.done_po    <= 1'b0;
    end else begin
      btn_q          <= bus.btn_pi;
      bus.counter_po <= bus.counter_po + CNT_ONE;
      bus.done_po    <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (op_sel != 4'b0000) begin
            bus.data1_po <= bus.sw_a_pi;
            bus.data2_po <= bus.sw_b_pi;
            bus.op_po    <= op_sel;
            exec_cnt_q   <= EXEC_LOAD;
            bus.busy_po  <= 1'b1;
            state_q      <= EXEC;
          end else if (press[3]) begin
            bus.result_po <= 8'h00;
            bus.ovflw_po  <= 1'b0;
            bus.done_po   <= 1'b1;
            bus.busy_po   <= 1'b1;
            state_q       <= WAIT_REL;
          end
        end

        EXEC: begin
          if (exec_cnt_q == 4'd0) begin
            bus.result_po <= bus.calc_result_pi;
            // Multiplication of two 4-bit values always fits in 8 bits.
            bus.ovflw_po  <= bus.op_po[2] ? 1'b0 : bus.calc_ovflw_pi;
            bus.done_po   <= 1'b1;
            bus.op_po     <= 4'b0000;
            state_q       <= WAIT_REL;
          end else begin
            exec_cnt_q <= exec_cnt_q - 4'd1;
          end
        end

        WAIT_REL: begin
          if (bus.btn_pi == 4'b0000) begin
            bus.busy_po <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          bus.op_po   <= 4'b0000;
          bus.busy_po <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule
